// File: rtl/phv_out_scheduler_pkg.sv
// Shared constants and types for the PHV output scheduler and the last match-action stage.
// Holds the PHV geometry defaults, the queue-select width helper and the FSM encoding.
package phv_out_scheduler_pkg;

    localparam int PHV_LEN_DEFAULT       = 32*64+256;
    localparam int PHV_QUEUE_BIT_OFFSET  = 141;
    localparam int C_NUM_QUEUES_DEFAULT  = 4;
    localparam int WEIGHT_WIDTH_DEFAULT  = 4;

    // A single-queue build still needs a 1-bit select so port widths stay legal.
    function automatic int qsel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int QSEL_W = qsel_width(C_NUM_QUEUES_DEFAULT);

    typedef enum logic {
        SCHED_IDLE  = 1'b0,
        SCHED_SERVE = 1'b1
    } sched_state_e;

endpackage

// File: rtl/phv_out_scheduler_if.sv
// Bundle of the FIFO-side, deparser-side and weight-config signals of the PHV output scheduler.
// slave is the scheduler's view; master is the view of the surrounding pipeline.
interface phv_out_scheduler_if
    import phv_out_scheduler_pkg::*;
#(
    parameter int PHV_LEN      = PHV_LEN_DEFAULT,
    parameter int C_NUM_QUEUES = C_NUM_QUEUES_DEFAULT,
    parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEFAULT,
    parameter int SEL_W        = qsel_width(C_NUM_QUEUES)
) ();

    logic [PHV_LEN*C_NUM_QUEUES-1:0]      phv_in;
    logic [C_NUM_QUEUES-1:0]              phv_in_valid;
    logic [C_NUM_QUEUES-1:0]              phv_in_ready;
    logic [PHV_LEN-1:0]                   phv_out;
    logic                                 phv_out_valid;
    logic                                 phv_out_ready;
    logic [SEL_W-1:0]                     queue_sel_out;
    logic [WEIGHT_WIDTH*C_NUM_QUEUES-1:0] weight_cfg;
    logic                                 weight_cfg_valid;

    modport slave (
        input  phv_in, phv_in_valid, phv_out_ready, weight_cfg, weight_cfg_valid,
        output phv_in_ready, phv_out, phv_out_valid, queue_sel_out
    );

    modport master (
        output phv_in, phv_in_valid, phv_out_ready, weight_cfg, weight_cfg_valid,
        input  phv_in_ready, phv_out, phv_out_valid, queue_sel_out
    );

endinterface

// File: rtl/phv_out_scheduler_rr_priority_pick.sv
// Rotating-priority encoder: returns the first set request found scanning upward from start_i,
// wrapping modulo C_NUM_QUEUES. Purely combinational; shared by several arbiters.
module rr_priority_pick
    import phv_out_scheduler_pkg::*;
#(
    parameter int C_NUM_QUEUES = C_NUM_QUEUES_DEFAULT,
    parameter int SEL_W        = qsel_width(C_NUM_QUEUES)
) (
    input  logic [C_NUM_QUEUES-1:0] req_i,
    input  logic [SEL_W-1:0]        start_i,
    output logic [SEL_W-1:0]        grant_o,
    output logic                    grant_valid_o
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        grant_o       = '0;
        grant_valid_o = 1'b0;
        for (int i = 0; i < C_NUM_QUEUES; i++) begin
            if (!grant_valid_o && req_i[(int'(start_i) + i) % C_NUM_QUEUES]) begin
                grant_o       = SEL_W'((int'(start_i) + i) % C_NUM_QUEUES);
                grant_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/phv_out_scheduler.sv
// Weighted round-robin drain of the per-queue PHV FIFOs into one registered PHV stream.
// A queue keeps the grant while it has credit; otherwise the next valid queue after next_ptr wins.
module phv_out_scheduler
    import phv_out_scheduler_pkg::*;
#(
    parameter int PHV_LEN      = PHV_LEN_DEFAULT,
    parameter int C_NUM_QUEUES = C_NUM_QUEUES_DEFAULT,
    parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEFAULT,
    parameter int SEL_W        = qsel_width(C_NUM_QUEUES)
) (
    input  logic                 axis_clk,
    input  logic                 aresetn,
    phv_out_scheduler_if.slave   bus
);

    sched_state_e              state_q, state_d;
    logic [SEL_W-1:0]          cur_queue_q, cur_queue_d;
    logic [WEIGHT_WIDTH-1:0]   credit_q, credit_d;
    logic [SEL_W-1:0]          next_ptr_q, next_ptr_d;
    logic [WEIGHT_WIDTH-1:0]   weights_q [C_NUM_QUEUES];
    logic [WEIGHT_WIDTH-1:0]   weights_d [C_NUM_QUEUES];
    logic [PHV_LEN-1:0]        phv_out_q, phv_out_d;
    logic                      phv_out_valid_q, phv_out_valid_d;
    logic [SEL_W-1:0]          queue_sel_q, queue_sel_d;

    logic [SEL_W-1:0]          pick_idx;
    logic                      pick_valid;
    logic                      continue_grant;
    logic [SEL_W-1:0]          grant_idx;
    logic                      grant_valid;
    logic                      slot_free;
    logic                      fire;
    logic [WEIGHT_WIDTH-1:0]   grant_weight;

    rr_priority_pick #(
        .C_NUM_QUEUES (C_NUM_QUEUES),
        .SEL_W        (SEL_W)
    ) u_pick (
        .req_i         (bus.phv_in_valid),
        .start_i       (next_ptr_q),
        .grant_o       (pick_idx),
        .grant_valid_o (pick_valid)
    );

    // An empty cur_queue forfeits its credit: the search result is used in the same cycle.
    assign continue_grant = (credit_q != '0) && bus.phv_in_valid[cur_queue_q];
    assign grant_idx      = continue_grant ? cur_queue_q : pick_idx;
    assign grant_valid    = continue_grant | pick_valid;
    assign slot_free      = ~phv_out_valid_q | bus.phv_out_ready;
    assign fire           = grant_valid & slot_free & aresetn;
    assign grant_weight   = weights_q[grant_idx];

    always_comb begin
        bus.phv_in_ready = '0;
        if (fire) bus.phv_in_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        state_d         = state_q;
        cur_queue_d     = cur_queue_q;
        credit_d        = credit_q;
        next_ptr_d      = next_ptr_q;
        weights_d       = weights_q;
        phv_out_d       = phv_out_q;
        phv_out_valid_d = phv_out_valid_q;
        queue_sel_d     = queue_sel_q;

        case (state_q)
            SCHED_IDLE:  if (|bus.phv_in_valid) state_d = SCHED_SERVE;
            SCHED_SERVE: if (!(|bus.phv_in_valid) && !fire) state_d = SCHED_IDLE;
            default:     state_d = SCHED_IDLE;
        endcase

        if (fire) begin
            phv_out_d       = bus.phv_in[int'(grant_idx)*PHV_LEN +: PHV_LEN];
            queue_sel_d     = grant_idx;
            phv_out_valid_d = 1'b1;
            if (continue_grant) begin
                credit_d = credit_q - 1'b1;
            end else begin
                // Weight 0 behaves as 1, so a freshly granted queue leaves with max(w,1)-1 credit.
                cur_queue_d = grant_idx;
                credit_d    = (grant_weight == '0) ? '0 : grant_weight - 1'b1;
                next_ptr_d  = grant_idx + 1'b1;
            end
        end else if (bus.phv_out_ready) begin
            phv_out_valid_d = 1'b0;
        end

        // The grant above already read the old weights; the new set only affects later reloads.
        if (bus.weight_cfg_valid) begin
            for (int i = 0; i < C_NUM_QUEUES; i++) begin
                weights_d[i] = bus.weight_cfg[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            state_q         <= SCHED_IDLE;
            cur_queue_q     <= '0;
            credit_q        <= '0;
            next_ptr_q      <= '0;
            // NOTE: the weight array is a handful of flops, so it is reset to 1 (plain round robin) rather than left unknown.
            for (int i = 0; i < C_NUM_QUEUES; i++) begin
                weights_q[i] <= WEIGHT_WIDTH'(1);
            end
            phv_out_q       <= '0;
            phv_out_valid_q <= 1'b0;
            queue_sel_q     <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge value of the others.
            state_q         <= state_d;
            cur_queue_q     <= cur_queue_d;
            credit_q        <= credit_d;
            next_ptr_q      <= next_ptr_d;
            weights_q       <= weights_d;
            phv_out_q       <= phv_out_d;
            phv_out_valid_q <= phv_out_valid_d;
            queue_sel_q     <= queue_sel_d;
        end
    end

    assign bus.phv_out       = phv_out_q;
    assign bus.phv_out_valid = phv_out_valid_q;
    assign bus.queue_sel_out = queue_sel_q;

endmodule

// File: doc/phv_out_scheduler.md
# phv_out_scheduler

Weighted round-robin scheduler that drains the per-output-queue PHV FIFOs filled by the last match-action stage and presents one PHV stream to the deparser. Each of the C_NUM_QUEUES FIFOs (one per one-hot queue bit of the PHV) is a requester. Grants are per PHV, with a configurable weight per queue. Output is one registered stage with valid/ready backpressure.

## Interface
- PHV_LEN, 32*64+256: PHV width in bits.
- C_NUM_QUEUES, 4: number of requesting FIFOs; power of two.
- WEIGHT_WIDTH, 4: width of each per-queue weight and of the credit counter.

Ports:
- axis_clk  in  1  clock.
- aresetn  in  1  synchronous, active-low reset.
- phv_in  in  PHV_LEN*C_NUM_QUEUES  FIFO head data; queue i occupies [i*PHV_LEN +: PHV_LEN].
- phv_in_valid  in  C_NUM_QUEUES  FIFO i is non-empty.
- phv_in_ready  out  C_NUM_QUEUES  pop strobe to FIFO i; at most one bit set per cycle.
- phv_out  out  PHV_LEN  scheduled PHV to the deparser.
- phv_out_valid  out  1  phv_out holds a PHV.
- phv_out_ready  in  1  deparser accepts phv_out this cycle.
- queue_sel_out  out  log2(C_NUM_QUEUES)  source queue of the current phv_out.
- weight_cfg  in  WEIGHT_WIDTH*C_NUM_QUEUES  per-queue weights; queue i occupies [i*WEIGHT_WIDTH +: WEIGHT_WIDTH].
- weight_cfg_valid  in  1  latches weight_cfg into the weight registers.

## Operation
- State registers:
  - cur_q: queue currently holding credit.
  - credit: remaining grants for cur_q.
  - next_ptr: search start for the next queue.
  - weights: per-queue weight registers.
- FSM has two states:
  - IDLE: phv_in_valid == 0. Moves to SERVE the first cycle any bit is set.
  - SERVE: moves back to IDLE when phv_in_valid == 0 and no grant fires.
- Output slot free means ~phv_out_valid | phv_out_ready.
- Grant selection, combinational:
  - If credit != 0 and phv_in_valid[cur_q], grant cur_q.
  - Otherwise grant the first valid queue found scanning next_ptr, next_ptr+1, … (mod C_NUM_QUEUES).
  - No valid queue means no grant.
- Fire: a grant exists and the output slot is free. On fire:
  - phv_in_ready[g] = 1.
  - phv_out <= phv_in[g], queue_sel_out <= g, phv_out_valid <= 1.
- Credit update on fire:
  - Continuing grant: credit <= credit-1.
  - Search grant: cur_q <= g, credit <= max(weights[g],1)-1, next_ptr <= (g+1) mod C_NUM_QUEUES.
- Weight 0 is treated as 1, so every valid queue is always served.
- Unused credit is forfeited when cur_q goes empty; the search then proceeds from next_ptr in the same cycle, with no bubble.
- No fire with phv_out_ready = 1: phv_out_valid <= 0.
- No fire with phv_out_valid = 1 and phv_out_ready = 0: phv_out and queue_sel_out are held.
- weight_cfg_valid: weights <= weight_cfg. A reload in the same cycle uses the old weights; the credit already loaded is not altered.

## Timing
- Reset values:
  - phv_out = 0, phv_out_valid = 0, queue_sel_out = 0, phv_in_ready = 0.
  - cur_q = 0, credit = 0, next_ptr = 0, all weights = 1 (plain round robin), FSM = IDLE.
- Latency: phv_out_valid rises 1 cycle after the fire cycle.
- Throughput: 1 PHV/cycle while phv_out_ready = 1 and any queue is valid.
- phv_in_ready is combinational from phv_in_valid, the registered state and phv_out_ready. Pop and capture happen in the same edge.
- phv_in_ready is never asserted while the output slot is occupied and stalled.
- Reset mid-operation: any held phv_out is discarded and no pop occurs in the reset cycle. The FIFOs keep their contents.

## Structure
- Shared header/package holds:
  - localparam QSEL_W = log2(C_NUM_QUEUES).
  - The PHV queue-bit offset (141) and PHV_LEN default, shared with the last stage.
  - FSM state encodings SCHED_IDLE and SCHED_SERVE.
- Sub-module rr_priority_pick: rotating-priority encoder with inputs req[C_NUM_QUEUES] and start pointer, outputs grant index and grant-valid. Reused by other arbiters.

## Test plan
- Reset check: hold aresetn = 0 for 3 cycles with all queues valid. All outputs stay 0 and phv_in_ready stays 0000.
- Plain round robin: weights all 1, all 4 queues continuously valid, phv_out_ready = 1. queue_sel_out sequence is 0,1,2,3,0,1 with one PHV per cycle. First valid output appears 1 cycle after the first pop.
- Weighted: weight_cfg = {q3 = 2, q2 = 0, q1 = 1, q0 = 3}, all queues valid. Sequence is 0,0,0,1,2,3,3,0,0,0.
- Single requester: only q2 valid for 10 cycles. q2 is served every cycle with no bubbles at credit reloads.
- Backpressure: phv_out_ready = 0 for 5 cycles while phv_out_valid = 1. phv_out and queue_sel_out are stable, phv_in_ready = 0000, and no PHV is lost or duplicated after release.
- Forfeit and reconfig: q1 goes empty after 1 of 3 credits. The next grant is q2 in the same cycle. A weight_cfg_valid issued in that cycle affects only later reloads.
